add_serial_n: RTL and testbench

- Parametrised bit-serial adder/subtractor; the multi-bit, sequential successor to the 1-bit full-adder cell.
- Accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Returns sum, carry-out and signed overflow with a one-cycle done pulse.
- Serves as an area-minimal arithmetic unit for slow datapaths, and as the verification vehicle for the full-adder cell in sequential use.

---
 rtl/add_pkg.sv | 24 ++
 rtl/add_full_1.sv | 13 +
 rtl/add_serial_n.sv | 132 +++++++++++++
 tb/tb_add_serial_n.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder family: FSM state encoding and
// a constant-evaluable ceil(log2) helper for sizing counters.
package add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Minimum number of bits needed to count 0..value-1.
    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/add_full_1.sv
// Single-bit full-adder cell; the per-bit arithmetic element of the serial adder.
module add_full_1 (
    output logic co,
    output logic s,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_serial_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell with a registered carry; sum/co/ovf update with a done pulse.
module add_serial_n
    import add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int            CW   = clog2_f(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic [WIDTH-1:0] s_next;

    add_full_1 u_fa (
        .co (fa_co),
        .s  (fa_s),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q)
    );

    // New sum bit enters at the MSB so the final word is LSB-aligned after WIDTH shifts.
    assign s_next = {fa_s, {(WIDTH-1){1'b0}}} | (s_sh_q >> 1);
    assign load   = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_next;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = s_next;
                    co_d    = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Subtract is A + ~B + ~borrow, so inversion happens once at load time.
        if (load) begin
            state_d = S_RUN;
            a_sh_d  = a;
            b_sh_d  = b ^ {WIDTH{sub}};
            carry_d = ci ^ sub;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_serial_n.sv
// Self-checking bench for add_serial_n (WIDTH=8): vector table plus scoreboard
// queue, with hand-written handshake and reset-abort sequences.
module tb_add_serial_n;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
        int               start_cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;

    add_serial_n #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            checkOutput("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checkOutput("sum", 64'(sum), 64'(e.sum));
                checkOutput("co", 64'(co), 64'(e.co));
                checkOutput("ovf", 64'(ovf), 64'(e.ovf));
                checkOutput("latency", 64'(cyc - e.start_cyc), 64'(WIDTH));
                checkOutput("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; drives one start pulse once the DUT is not busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                 input logic ci_i, input logic sub_i,
                                 input logic [WIDTH-1:0] s_exp, input logic co_exp,
                                 input logic ovf_exp, input bit push);
        exp_t e;
        int   waited;
        waited = 0;
        while (busy && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (busy) checkOutput("busy_timeout", 64'(busy), 64'd0);
        a     = a_i;
        b     = b_i;
        ci    = ci_i;
        sub   = sub_i;
        start = 1'b1;
        if (push) begin
            e.sum       = s_exp;
            e.co        = co_exp;
            e.ovf       = ovf_exp;
            e.start_cyc = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int busyCnt;
        int n;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'd5,  8'd7,  1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'd10, 8'd3,  1'b1, 1'b1, 8'd6,  1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
        sub   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_co", 64'(co), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
        end

        $display("[TB] basic add with busy window");
        applyStimulus(8'd100, 8'd27, 1'b0, 1'b0, 8'd127, 1'b0, 1'b0, 1'b1);
        busyCnt = 0;
        while (busy && busyCnt < 50) begin
            busyCnt++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 64'(busyCnt), 64'(WIDTH));
        checkOutput("done_with_busy_low", 64'(done), 64'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        waitDrain();

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
                          vecs[i].sum, vecs[i].co, vecs[i].ovf, 1'b1);
            waitDrain();
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(8'd20, 8'd22, 1'b0, 1'b0, 8'd42, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'd99;
        b     = 8'd1;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (12) @(negedge clk);
        checkOutput("sum_after_ignored", 64'(sum), 64'd42);

        $display("[TB] back-to-back start in DONE cycle");
        applyStimulus(8'd50, 8'd20, 1'b0, 1'b0, 8'd70, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!done && n < 30) begin
            n++;
            @(negedge clk);
        end
        checkOutput("b2b_done_seen", 64'(done), 64'd1);
        applyStimulus(8'd200, 8'd100, 1'b0, 1'b1, 8'd100, 1'b1, 1'b1, 1'b1);
        repeat (6) begin
            checkOutput("b2b_hold_sum", 64'(sum), 64'd70);
            checkOutput("b2b_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        waitDrain();

        $display("[TB] reset during RUN");
        applyStimulus(8'd1, 8'd2, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_sum", 64'(sum), 64'd0);
        checkOutput("abort_co", 64'(co), 64'd0);
        checkOutput("abort_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checkOutput("abort_no_done", 64'(done), 64'd0);
        end
        applyStimulus(8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1);
        waitDrain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
